// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing the UART TX FIFO write port between NREQ byte streams.
// A grant is held for a whole packet, bounded by a burst limit and an idle timeout.
module uart_tx_arb #(
  parameter int NREQ         = 4,
  parameter int MAX_BURST    = 64,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              enable_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic              fifo_full_i,
  output logic              fifo_wr_o,
  output logic [7:0]        fifo_wdata_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int IW = $clog2(HOLD_TIMEOUT);
  localparam logic [BW-1:0] BURST_LAST = BW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(HOLD_TIMEOUT - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   rr_ptr;
  logic [BW-1:0]   burst_cnt;
  logic [IW-1:0]   idle_cnt;

  logic [PW-1:0]   cand;
  logic [PW-1:0]   pick_idx;
  logic            pick_found;
  logic            xfer;
  logic            g_valid;
  logic            g_last;
  logic            hs;
  logic            burst_hit;
  logic            timeout_hit;
  logic            rel;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
    if (int'(idx) == NREQ - 1)
      return '0;
    else
      return idx + PW'(1);
  endfunction

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  assign xfer        = (state == XFER);
  assign g_valid     = xfer & req_valid_i[gidx];
  assign g_last      = req_last_i[gidx];
  assign hs          = g_valid & ~fifo_full_i;
  assign burst_hit   = (MAX_BURST != 0) && (burst_cnt == BURST_LAST);
  assign timeout_hit = xfer & ~req_valid_i[gidx] & (idle_cnt == IDLE_LAST);
  assign rel         = (hs & (g_last | burst_hit)) | timeout_hit;

  // Ready depends only on the grant and FIFO space, never on valid.
  assign req_ready_o  = (xfer & ~fifo_full_i) ? grant : '0;
  assign fifo_wr_o    = hs;
  assign fifo_wdata_o = hs ? req_data_i[{gidx, 3'b000} +: 8] : 8'h00;
  assign grant_o      = grant;
  assign busy_o       = xfer;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      grant     <= '0;
      gidx      <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i && pick_found) begin
            state     <= XFER;
            grant     <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            gidx      <= pick_idx;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        XFER: begin
          if (rel) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= wrap_inc(gidx);
          end else if (hs) begin
            burst_cnt <= burst_cnt + BW'(1);
            idle_cnt  <= '0;
          end else if (!req_valid_i[gidx]) begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: packet-level reference model checked every cycle,
// plus literal expectations on byte order, grant timing and reset behaviour.
module tb_uart_tx_arb;

  localparam int NREQ         = 4;
  localparam int MAX_BURST    = 4;
  localparam int HOLD_TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              enable;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full;
  logic              fifo_wr;
  logic [7:0]        fifo_wdata;
  logic [NREQ-1:0]   grant;
  logic              busy;

  uart_tx_arb #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .fifo_full_i(fifo_full), .fifo_wr_o(fifo_wr),
    .fifo_wdata_o(fifo_wdata), .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]  srcq [NREQ][$];
  logic [11:0] log_v[$];
  int          log_c[$];
  logic [11:0] expq[$];

  // Reference: owner (-1 = nobody), next-priority pointer, bytes in grant, quiet cycles.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_bytes = 0;
  int m_quiet = 0;
  int mk;
  logic [31:0] e_grant, e_ready, e_wr, e_wdata, e_busy;
  logic [3:0]  lsrc;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      if (srcq[k].size() > 0) begin
        req_valid[k]       = 1'b1;
        req_data[8*k +: 8] = srcq[k][0][7:0];
        req_last[k]        = srcq[k][0][8];
      end else begin
        req_valid[k]       = 1'b0;
        req_data[8*k +: 8] = 8'hEE;
        req_last[k]        = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    drive();
  end

  task automatic model_release();
    m_ptr   = (m_owner + 1) % NREQ;
    m_owner = -1;
  endtask

  // Compare process: model outputs vs DUT, then advance the model and the sources.
  initial forever begin
    @(negedge clk);
    e_grant = 0; e_ready = 0; e_wr = 0; e_wdata = 0; e_busy = 0;
    if (rstn && m_owner >= 0) begin
      e_grant = 1 << m_owner;
      e_busy  = 1;
      if (!fifo_full) e_ready = e_grant;
      if (req_valid[m_owner] && !fifo_full) begin
        e_wr    = 1;
        e_wdata = 32'(req_data[8*m_owner +: 8]);
      end
    end
    chk("grant", 32'(grant), e_grant);
    chk("busy", 32'(busy), e_busy);
    chk("ready", 32'(req_ready), e_ready);
    chk("wr", 32'(fifo_wr), e_wr);
    chk("wdata", 32'(fifo_wdata), e_wdata);

    if (fifo_wr) begin
      lsrc = 4'hF;
      for (int k = 0; k < NREQ; k++) if (grant[k]) lsrc = 4'(k);
      log_v.push_back({lsrc, fifo_wdata});
      log_c.push_back(cyc);
    end
    for (int k = 0; k < NREQ; k++)
      if (req_valid[k] && req_ready[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());

    if (!rstn) begin
      m_owner = -1; m_ptr = 0; m_bytes = 0; m_quiet = 0;
    end else if (m_owner < 0) begin
      if (enable) begin
        for (int i = 0; i < NREQ; i++) begin
          mk = (m_ptr + i) % NREQ;
          if (m_owner < 0 && req_valid[mk]) m_owner = mk;
        end
        m_bytes = 0;
        m_quiet = 0;
      end
    end else if (e_wr != 0) begin
      m_bytes++;
      m_quiet = 0;
      if (req_last[m_owner] || m_bytes == MAX_BURST) model_release();
    end else if (!req_valid[m_owner]) begin
      m_quiet++;
      if (m_quiet == HOLD_TIMEOUT) model_release();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    srcq[k].push_back({l, d});
  endtask

  task automatic ex(input int s, input logic [7:0] d);
    expq.push_back({s[3:0], d});
  endtask

  task automatic wait_log(input int n, input string nm);
    for (int i = 0; i < 200 && log_v.size() < n; i++) tick();
    chk(nm, 32'(log_v.size() >= n), 32'd1);
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] want, input string nm);
    for (int i = 0; i < 50 && grant !== want; i++) @(negedge clk);
    chk(nm, 32'(grant), 32'(want));
  endtask

  task automatic chk_log(input string nm, input int base);
    logic [31:0] got;
    chk({nm, "_len"}, log_v.size(), base + expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      got = (base + i < log_v.size()) ? 32'(log_v[base + i]) : 32'hFFFF;
      chk(nm, got, 32'(expq[i]));
    end
    expq.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  int base, t;

  initial begin
    rstn = 1'b0; enable = 1'b1; fifo_full = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    drive();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr", 32'(fifo_wr), 0);
    tick(); rstn = 1'b1;
    tick();

    // Round robin: req0 "AB\n" then "C\n", req2 "xy\n"
    base = log_v.size();
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h0A, 1); push(0, 8'h43, 0); push(0, 8'h0A, 1);
    push(2, 8'h78, 0); push(2, 8'h79, 0); push(2, 8'h0A, 1);
    wait_log(base + 8, "rr_wait");
    repeat (3) tick();
    ex(0, 8'h41); ex(0, 8'h42); ex(0, 8'h0A); ex(2, 8'h78); ex(2, 8'h79); ex(2, 8'h0A);
    ex(0, 8'h43); ex(0, 8'h0A);
    chk("rr_bubble", 32'(log_c[base + 3] - log_c[base + 2]), 32'd2);
    chk_log("rr_order", base);

    // Burst limit 4: req1 streams 10 bytes, req3 has a 2-byte packet
    base = log_v.size();
    for (int i = 0; i < 10; i++) push(1, 8'(16 + i), (i == 9));
    push(3, 8'h30, 0); push(3, 8'h31, 1);
    wait_log(base + 12, "burst_wait");
    repeat (3) tick();
    for (int i = 0; i < 4; i++) ex(1, 8'(16 + i));
    ex(3, 8'h30); ex(3, 8'h31);
    for (int i = 4; i < 10; i++) ex(1, 8'(16 + i));
    chk_log("burst_order", base);

    // Last and burst limit on the same byte rotate the pointer once
    base = log_v.size();
    for (int i = 0; i < 4; i++) push(0, 8'(8'h50 + i), (i == 3));
    wait_log(base + 4, "coin_wait");
    push(1, 8'h60, 1); push(2, 8'h70, 1);
    wait_log(base + 6, "coin_wait2");
    repeat (3) tick();
    for (int i = 0; i < 4; i++) ex(0, 8'(8'h50 + i));
    ex(1, 8'h60); ex(2, 8'h70);
    chk_log("coin_order", base);

    // Backpressure longer than the hold timeout
    base = log_v.size();
    push(3, 8'hA0, 0); push(3, 8'hA1, 0); push(3, 8'hA2, 1);
    wait_log(base + 1, "bp_wait");
    fifo_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_wr", 32'(fifo_wr), 0);
      chk("bp_grant", 32'(grant), 32'h8);
      tick();
    end
    fifo_full = 1'b0;
    wait_log(base + 3, "bp_wait2");
    repeat (3) tick();
    ex(3, 8'hA0); ex(3, 8'hA1); ex(3, 8'hA2);
    chk_log("bp_bytes", base);

    // Timeout: req0 stops without last, req1 waits
    base = log_v.size();
    push(0, 8'h80, 0); push(0, 8'h81, 0);
    wait_log(base + 2, "to_wait");
    t = log_c[base + 1];
    push(1, 8'h90, 1);
    while (cyc < t + 16) @(negedge clk);
    chk("to_held16", 32'(grant), 32'h1);
    @(negedge clk);
    chk("to_dropped17", 32'(grant), 32'h0);
    @(negedge clk);
    chk("to_next18", 32'(grant), 32'h2);
    wait_log(base + 3, "to_wait2");
    repeat (3) tick();
    ex(0, 8'h80); ex(0, 8'h81); ex(1, 8'h90);
    chk_log("to_bytes", base);

    // Enable gating
    enable = 1'b0;
    base = log_v.size();
    push(2, 8'hC0, 0); push(2, 8'hC1, 0); push(2, 8'hC2, 1);
    repeat (5) begin
      @(negedge clk);
      chk("en_off_grant", 32'(grant), 0);
    end
    tick(); enable = 1'b1;
    @(negedge clk);
    chk("en_lat0", 32'(grant), 0);
    tick(); enable = 1'b0;
    @(negedge clk);
    chk("en_grant", 32'(grant), 32'h4);
    wait_log(base + 3, "en_wait");
    repeat (3) tick();
    ex(2, 8'hC0); ex(2, 8'hC1); ex(2, 8'hC2);
    chk_log("en_bytes", base);
    base = log_v.size();
    push(3, 8'hD0, 1);
    repeat (5) begin
      @(negedge clk);
      chk("en_off2_grant", 32'(grant), 0);
    end
    tick();
    chk("en_off2_nowr", log_v.size(), base);
    srcq[3].delete();

    // Reset in the middle of a req1 packet
    enable = 1'b1;
    push(1, 8'hE0, 0); push(1, 8'hE1, 0); push(1, 8'hE2, 0);
    wait_grant(4'b0010, "rm_granted");
    tick();
    rstn = 1'b0;
    for (int k = 0; k < NREQ; k++) srcq[k].delete();
    @(negedge clk);
    chk("rm_grant", 32'(grant), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_wr", 32'(fifo_wr), 0);
    chk("rm_ready", 32'(req_ready), 0);
    tick(); rstn = 1'b1;
    tick();
    push(0, 8'hF0, 1); push(3, 8'hF3, 1);
    @(negedge clk);
    chk("rm_lat0", 32'(grant), 0);
    @(negedge clk);
    chk("rm_req0", 32'(grant), 32'h1);
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter that shares the peripheral UART transmit FIFO write port between NREQ byte-stream requesters, such as CPU console, debug monitor and test-harness injector.
- Sits in the peripheral wrapper in front of the UART TX FIFO write interface (wr/wdata/full).
- Holds a grant for a whole packet, up to a burst limit, so text lines from different sources never interleave mid-line.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 64, maximum bytes per grant before forced re-arbitration; 0 means unlimited.
- HOLD_TIMEOUT, 16, consecutive cycles without valid from the granted requester before its grant is dropped (>=2).

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- enable_i  in  1  arbiter enable; when low, no new grants are issued.
- req_valid_i  in  NREQ  per-requester byte valid.
- req_data_i  in  8*NREQ  per-requester byte; requester k uses bits [8k+7:8k].
- req_last_i  in  NREQ  marks the final byte of the requester's packet.
- req_ready_o  out  NREQ  per-requester byte accepted this cycle.
- fifo_full_i  in  1  UART TX FIFO full.
- fifo_wr_o  out  1  UART TX FIFO write strobe.
- fifo_wdata_o  out  8  UART TX FIFO write data.
- grant_o  out  NREQ  one-hot current grant; all zeros when none.
- busy_o  out  1  a grant is held (state XFER).

Behaviour:
- Reset (async, rstn_i low):
  - state=IDLE, grant=0, rr_ptr=0, burst_cnt=0, idle_cnt=0.
  - All outputs 0.
  - Reset mid-packet abandons the packet silently; no partial flush.
- States: IDLE, XFER.
- IDLE:
  - If enable_i=1 and any req_valid_i is set, pick the first set valid searching upward from rr_ptr, wrapping modulo NREQ.
  - Register the one-hot grant, clear burst_cnt and idle_cnt, go to XFER.
  - grant_o is visible the cycle after the request is sampled (1-cycle arbitration latency).
- XFER, with g = granted index:
  - req_ready_o[g] = ~fifo_full_i. All other req_ready_o bits are 0.
  - fifo_wr_o = req_valid_i[g] & ~fifo_full_i (combinational).
  - fifo_wdata_o = req_data_i[g] when fifo_wr_o=1, else 8'h00.
  - Handshake = fifo_wr_o. On a handshake: burst_cnt+1, idle_cnt cleared.
  - When req_valid_i[g]=0: idle_cnt+1, saturating.
  - fifo_full_i=1 with valid=1 stalls; idle_cnt is neither incremented nor cleared.
- Release (XFER -> IDLE next cycle, grant cleared, rr_ptr = (g+1) mod NREQ). Any of:
  - Handshake with req_last_i[g]=1.
  - Handshake where burst_cnt+1 == MAX_BURST (MAX_BURST != 0).
  - idle_cnt reaches HOLD_TIMEOUT-1 and valid is still low.
  - last and burst limit on the same byte: single release, no double rotation.
- Re-arbitration:
  - Minimum one IDLE cycle between grants, so back-to-back packets see a 1-cycle bubble.
  - A requester that just released has lowest priority at the next arbitration.
- enable_i:
  - Sampled only in IDLE. Deasserting enable_i during XFER lets the current grant run to its release.
- Ignored inputs:
  - req_data_i and req_last_i of non-granted requesters.
  - req_last_i without valid.
- burst_cnt width = clog2(MAX_BURST+1); it never wraps because release occurs at the limit.
- busy_o = (state==XFER).
- Combinational-loop rule: req_ready_o must not depend on req_valid_i.

Test Plan:
- Reset / idle: assert rstn_i low mid-XFER with req 1 granted -> same cycle all outputs 0; after release, a valid on req 0 gets grant_o=4'b0001 one cycle later.
- Round robin: req 0 and req 2 each send 3-byte packets ("AB\n", "xy\n"), continuously valid, FIFO never full.
  - fifo_wdata_o sequence is 41,42,0A, 78,79,0A.
  - One bubble cycle between packets.
  - Next grant goes to req 0 only after req 2 has been served.
- Burst limit: MAX_BURST=4, req 1 streams 10 bytes with last only on byte 10 and req 3 is also valid.
  - Order: 4 bytes from req1, then req3's packet, then the next 4 bytes of req1.
- Backpressure: fifo_full_i high for 5 cycles mid-packet -> req_ready_o[g]=0 and fifo_wr_o=0 throughout; no byte lost or duplicated; idle_cnt unchanged; no timeout release.
- Timeout: HOLD_TIMEOUT=16, granted req 0 drops valid without last.
  - Grant released exactly 16 cycles after the last handshake.
  - Pending req 1 granted 2 cycles later.
- Enable: enable_i=0 with req 2 valid -> grant_o stays 0.
  - enable_i=0 during XFER -> packet completes.
  - enable_i=1 again -> grant_o=4'b0100 one cycle later.
